// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared definitions for the UART transmit serializer.
//
// Contents:
//   state_t    FSM state encoding (PARITY exists only when UART_TX_PARITY_EN
//              is defined)
//   START_BIT  line level of the start bit (0)
//   STOP_BIT   line level of the stop bit and of the idle line (1)
//   idx_width  width of a counter that indexes 0..n-1, never less than 1
//
// Configuration macro: UART_TX_PARITY_EN
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- FIFO-read and serial-line signals of the UART serializer.
//
// Signals:
//   tx_en       enable for starting new frames
//   fifo_data   show-ahead head word of the upstream FIFO
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_en  one-cycle pop strobe to the FIFO
//   tx          serial line, idles high
//   busy        serializer is not idle
//   frame_done  one-cycle pulse on the final cycle of the stop bit
//
// Modports:
//   master  the serializer (pops the FIFO, drives the line)
//   slave   the surrounding system (FIFO and line receiver)
interface uart_tx_if #(
  parameter int WIDTH = 8
) ();

  logic             tx_en;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport master (
    input  tx_en, fifo_data, fifo_empty,
    output fifo_rd_en, tx, busy, frame_done
  );

  modport slave (
    output tx_en, fifo_data, fifo_empty,
    input  fifo_rd_en, tx, busy, frame_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART serializer.
//
// Counts 0..CLKS_PER_BIT-1 and wraps. restart reloads the count to 0 on the
// next edge, so the owning FSM can align every bit period to a state entry.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   restart  reload the count to 0
//   bit_end  high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_end = (cnt_q == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (rst || restart || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer -- pops words from a show-ahead FIFO and sends them as
// UART frames: start bit (0), WIDTH data bits LSB first, optional even-parity
// bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks. When the FIFO still
// has data at the end of a stop bit, the next frame follows with no gap.
//
// Parameters:
//   WIDTH         data bits per frame (must match the interface WIDTH)
//   CLKS_PER_BIT  clocks per serial bit, 2 or more
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset; aborts any frame in progress
//   bus   uart_tx_if master: tx_en, fifo_data, fifo_empty in;
//         fifo_rd_en, tx, busy, frame_done out
//
// Configuration macro: UART_TX_PARITY_EN adds a PARITY state between DATA
// and STOP carrying the XOR of the data bits.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.master bus
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             pop;
  logic             done;
  logic             can_start;
  logic             bit_end;
  logic             restart;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign can_start = bus.tx_en && !bus.fifo_empty;

  // The counter sits at 0 while idle and reloads whenever the state changes,
  // so every bit state starts from a full bit period.
  assign restart = (state_q == IDLE) || (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_end (bit_end)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done = 1'b1;
          // Chaining straight into START keeps back-to-back frames gapless.
          if (can_start) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = bus.fifo_data;
    end

    // tx is registered from the next state, so the line changes on the same
    // edge as the state and no input reaches tx combinationally.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is cleared on reset as well, so a frame cut
      // short leaves no stale data behind.
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity is fixed at the pop cycle, like the data itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^bus.fifo_data;
    end
  end
`endif

  // Strobes are gated by rst so no pop or pulse escapes during reset.
  assign bus.fifo_rd_en = pop && !rst;
  assign bus.frame_done = done && !rst;
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx         = tx_q;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame; it matches the upstream FIFO word width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range is 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit, the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port tx_en, input, 1 bit; while high, new frames may start.
REQ-006 SHALL have port fifo_data, input, WIDTH bits, the show-ahead head word of the upstream FIFO, valid whenever fifo_empty is low.
REQ-007 SHALL have port fifo_empty, input, 1 bit, the upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en, output, 1 bit, a one-cycle pop strobe to the upstream FIFO.
REQ-009 SHALL have port tx, output, 1 bit, the serial line, which idles high.
REQ-010 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-011 SHALL have port frame_done, output, 1 bit, a one-cycle pulse on the final cycle of STOP.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (present only with the macro), and STOP.
REQ-013 SHALL hold each bit state for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0 to CLKS_PER_BIT-1, reloads to 0 on every state entry, and is sized $clog2(CLKS_PER_BIT).
REQ-014 SHALL, in IDLE with tx_en=1 and fifo_empty=0, assert fifo_rd_en for that cycle, capture fifo_data into the shift register on the same edge, and enter START; tx goes low on the next cycle (1-cycle latency).
REQ-015 SHALL drive tx=0 in START, then transmit the WIDTH data bits LSB first in DATA, using a bit index 0..WIDTH-1, then drive tx=1 in STOP.
REQ-016 SHALL register the tx output, with no combinational path from any input to tx.
REQ-017 SHALL, on the final cycle of STOP with tx_en=1 and fifo_empty=0, pop and capture the next word and enter START directly, so frames are back-to-back with no idle gap.
REQ-018 SHALL, on the final cycle of STOP otherwise, go to IDLE.
REQ-019 SHALL never assert fifo_rd_en while fifo_empty=1, and SHALL assert it at most once per frame.
REQ-020 SHALL, if tx_en is deasserted mid-frame, complete the current frame and start no new one.
REQ-021 SHALL ignore fifo_data changes after capture; the frame content is fixed at the pop cycle.

Reset
REQ-022 SHALL, when rst=1 on a clock edge, force state to IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, and clear the baud counter, bit index and shift register to 0.
REQ-023 SHALL abort any frame in progress on reset mid-frame, with tx high on the cycle after the reset edge and no pop issued during reset.

Configuration
REQ-024 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP that transmits the even-parity bit (XOR of the WIDTH data bits) for CLKS_PER_BIT cycles.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, contain no parity logic and go from DATA to STOP directly.

Structure
REQ-026 SHALL take from shared package uart_tx_pkg the FSM state enum type and the START_BIT=0 and STOP_BIT=1 constants.
REQ-027 SHALL instantiate one sub-module, uart_baud_gen, holding the baud counter with inputs clk, rst and restart, and output bit_end asserted on count CLKS_PER_BIT-1.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-028 SHALL verify a single word: present 0xA5 with empty=0 and tx_en=1 -> one rd_en pulse, tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles, frame_done on cycle 40, then IDLE.
REQ-029 SHALL verify back-to-back words: queue 0x00 then 0xFF -> exactly 2 rd_en pulses 40 cycles apart, no idle gap between stop and start, and busy high throughout.
REQ-030 SHALL verify that a constantly empty FIFO keeps tx=1, busy=0 and fifo_rd_en=0 for 100 cycles.
REQ-031 SHALL verify reset mid-DATA: assert rst at cycle 15 of a frame -> the next cycle shows tx=1, busy=0, no pop; after release a fresh frame starts on the next word.
REQ-032 SHALL verify tx_en low at cycle 10 with 3 words queued -> the current frame completes, exactly 1 pop in total, and the remaining words stay in the FIFO.
REQ-033 SHALL verify that with UART_TX_PARITY_EN defined, 0x07 produces parity bit 1 and a 44-cycle frame, and 0x03 produces parity bit 0.
